// File: rtl/seq_shifter_if.sv
// Start/ready/done handshake plus operand and result bus for the multi-cycle shifter.
interface seq_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, mode, operand, shamt,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, mode, operand, shamt,
    output ready, busy, done, result
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit that moves at most STEP bit positions per clock,
// so the control FSM can stall on ready/done instead of paying for a full barrel shifter.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_shifter_if.slave bus
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [1:0]         mode_q;
  logic               sign_q;
  logic [SHAMT_W-1:0] remaining;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   k;
  logic               last_step;
  logic [WIDTH-1:0]   next_work;

  // Small mux over 0..STEP positions; SRA fills from the sign captured at start.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       m,
    input logic             s,
    input logic [SHAMT_W:0] amt
  );
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] ext;
    r   = w;
    ext = {{WIDTH{s}}, w};
    for (int i = 1; i <= STEP; i++) begin
      if (amt == (SHAMT_W+1)'(i)) begin
        case (m)
          MODE_SLL: r = w << i;
          MODE_SRL: r = w >> i;
          MODE_SRA: r = ext[i +: WIDTH];
          default:  r = (w >> i) | (w << (WIDTH - i));
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    rem_ext   = {1'b0, remaining};
    k         = (rem_ext < STEP_K) ? rem_ext : STEP_K;
    last_step = (rem_ext <= STEP_K);
    next_work = shift_step(work, mode_q, sign_q, k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      mode_q    <= '0;
      sign_q    <= 1'b0;
      remaining <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work    <= bus.operand;
            mode_q  <= bus.mode;
            sign_q  <= bus.operand[WIDTH-1];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.shamt == '0) begin
              state     <= DONE;
              done_q    <= 1'b1;
              result_q  <= bus.operand;
              remaining <= '0;
            end else begin
              state     <= SHIFT;
              remaining <= bus.shamt;
            end
          end
        end
        SHIFT: begin
          work <= next_work;
          if (last_step) begin
            state     <= DONE;
            done_q    <= 1'b1;
            result_q  <= next_work;
            remaining <= '0;
          end else begin
            remaining <= remaining - k[SHAMT_W-1:0];
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
